// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants, address types and read-side state for Conv1
package conv_pkg;

   localparam int IMG_W  = 28;
   localparam int K      = 5;
   localparam int OUT_W  = IMG_W - K + 1;
   localparam int N_TAPS = K * K;
   localparam int N_WIN  = OUT_W * OUT_W;

   typedef logic [9:0] pix_addr_t;
   typedef logic [4:0] wt_addr_t;

   typedef enum logic {
      RUN  = 1'b0,
      DONE = 1'b1
   } rd_state_t;

   // Constants arrive as int; narrow them once so the datapath stays 10-bit.
   function automatic pix_addr_t to_pix(input int v);
      return pix_addr_t'(v);
   endfunction

   // Jump from the end of one kernel row to the start of the next.
   localparam pix_addr_t TAP_ROW_STEP = to_pix(IMG_W - (K - 1));
   // Jump from the last window of an output row to the first of the next.
   localparam pix_addr_t WIN_ROW_STEP = to_pix(IMG_W - (OUT_W - 1));

endpackage

// File: rtl/conv1_mem_read_if.sv
// rtl/conv1_mem_read_if.sv - tap address bus between the Conv1 read generator and the MAC
interface conv1_mem_read_if;
   import conv_pkg::*;

   logic      enable;
   pix_addr_t pix_addr;
   wt_addr_t  wt_addr;
   pix_addr_t win_idx;
   logic      valid;
   logic      last_tap;
   logic      done;

   modport master (
      input  enable,
      output pix_addr,
      output wt_addr,
      output win_idx,
      output valid,
      output last_tap,
      output done
   );

   modport slave (
      output enable,
      input  pix_addr,
      input  wt_addr,
      input  win_idx,
      input  valid,
      input  last_tap,
      input  done
   );

endinterface

// File: rtl/conv_win_counter.sv
// rtl/conv_win_counter.sv - two-level (x,y) raster counter with end flags and carry-out
module conv_win_counter #(
   parameter int X_MAX = 4,
   parameter int Y_MAX = 4,
   parameter bit WRAP  = 1'b1,
   parameter int W     = $clog2(((X_MAX > Y_MAX) ? X_MAX : Y_MAX) + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic step,
   output logic x_last,
   output logic y_last,
   output logic carry
);

   logic [W-1:0] x;
   logic [W-1:0] y;

   assign x_last = (x == W'(X_MAX));
   assign y_last = (y == W'(Y_MAX));
   // Carry fires on the step that leaves the final (x,y) position.
   assign carry  = step && x_last && y_last;

   // Advance x, roll into y; at the end either wrap to origin or hold.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x <= '0;
         y <= '0;
      end else if (step) begin
         if (!x_last) begin
            x <= x + 1'b1;
         end else if (!y_last) begin
            x <= '0;
            y <= y + 1'b1;
         end else if (WRAP) begin
            x <= '0;
            y <= '0;
         end
      end
   end

endmodule

// File: rtl/conv1_mem_read.sv
// rtl/conv1_mem_read.sv - Conv1 input/weight address generator; CONV1_RD_PIPE_EN delays valid/last_tap/win_idx one cycle
module conv1_mem_read
   import conv_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   conv1_mem_read_if.master rd
);

   rd_state_t state;
   logic      live;
   logic      kx_last;
   logic      ky_last;
   logic      tap_carry;
   logic      ox_last;
   logic      oy_last;
   logic      win_carry;
   logic      tap_end;
   pix_addr_t win_base;
   pix_addr_t tap_off;
   pix_addr_t win_idx_r;
   wt_addr_t  wt_r;

   // A tap is issued whenever the sweep is running and the MAC allows it.
   assign live    = (state == RUN) && rd.enable;
   assign tap_end = kx_last && ky_last;

   conv_win_counter #(
      .X_MAX (K - 1),
      .Y_MAX (K - 1),
      .WRAP  (1'b1)
   ) u_tap_cnt (
      .clk    (clk),
      .reset  (reset),
      .step   (live),
      .x_last (kx_last),
      .y_last (ky_last),
      .carry  (tap_carry)
   );

   conv_win_counter #(
      .X_MAX (OUT_W - 1),
      .Y_MAX (OUT_W - 1),
      .WRAP  (1'b0)
   ) u_win_cnt (
      .clk    (clk),
      .reset  (reset),
      .step   (tap_carry),
      .x_last (ox_last),
      .y_last (oy_last),
      .carry  (win_carry)
   );

   // Sweep FSM: leaves RUN after the last tap of the last window, only reset returns.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= RUN;
      end else if (state == RUN && win_carry) begin
         state <= DONE;
      end
   end

   // Tap offset within the image, stepped alongside kx/ky.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tap_off <= '0;
      end else if (live) begin
         if (!kx_last) begin
            tap_off <= tap_off + 10'd1;
         end else if (!ky_last) begin
            tap_off <= tap_off + TAP_ROW_STEP;
         end else begin
            tap_off <= '0;
         end
      end
   end

   // Weight address follows the tap number, restarting with each window.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wt_r <= '0;
      end else if (live) begin
         wt_r <= tap_carry ? '0 : wt_r + 5'd1;
      end
   end

   // Window origin and index step once per completed window; final window holds.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         win_base  <= '0;
         win_idx_r <= '0;
      end else if (tap_carry) begin
         if (!ox_last) begin
            win_base  <= win_base + 10'd1;
            win_idx_r <= win_idx_r + 10'd1;
         end else if (!oy_last) begin
            win_base  <= win_base + WIN_ROW_STEP;
            win_idx_r <= win_idx_r + 10'd1;
         end
      end
   end

   assign rd.pix_addr = win_base + tap_off;
   assign rd.wt_addr  = wt_r;

`ifdef CONV1_RD_PIPE_EN
   logic      valid_q;
   logic      last_q;
   logic      done_q;
   pix_addr_t win_idx_q;

   // Delay tap qualifiers by one cycle to line up with synchronous RAM read data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         win_idx_q <= '0;
         done_q    <= 1'b0;
      end else begin
         valid_q   <= live;
         last_q    <= live && tap_end;
         win_idx_q <= win_idx_r;
         done_q    <= (state == DONE);
      end
   end

   assign rd.valid    = valid_q;
   assign rd.last_tap = last_q;
   assign rd.win_idx  = win_idx_q;
   assign rd.done     = done_q;
`else
   assign rd.valid    = live;
   assign rd.last_tap = live && tap_end;
   assign rd.win_idx  = win_idx_r;
   assign rd.done     = (state == DONE);
`endif

endmodule

// File: tb/tb_conv1_mem_read.sv
// tb/tb_conv1_mem_read.sv - self-checking bench for conv1_mem_read
module tb_conv1_mem_read;
   import conv_pkg::*;

`ifdef CONV1_RD_PIPE_EN
   localparam bit PIPE = 1'b1;
`else
   localparam bit PIPE = 1'b0;
`endif
   localparam int NT = N_WIN * N_TAPS;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   conv1_mem_read_if ifc();

   conv1_mem_read dut (
      .clk   (clk),
      .reset (reset),
      .rd    (ifc)
   );

   always #5 clk = ~clk;

   typedef struct {
      int n;
      int pix;
      int wt;
      int win;
      int last;
   } vec_t;

   vec_t tbl[12];
   vec_t q[$];
   int   nvec   = 0;
   int   errs   = 0;
   int   n      = 0;
   int   vcount = 0;
   int   prev_pix = 0;
   int   prev_wt  = 0;
   int   fd;

   function automatic vec_t model(input int idx);
      vec_t r;
      int w, t, ox, oy, kx, ky;
      w  = idx / N_TAPS;
      t  = idx % N_TAPS;
      oy = w / OUT_W;
      ox = w % OUT_W;
      ky = t / K;
      kx = t % K;
      r.n    = idx;
      r.pix  = (oy + ky) * IMG_W + ox + kx;
      r.wt   = t;
      r.win  = w;
      r.last = (t == N_TAPS - 1) ? 1 : 0;
      return r;
   endfunction

   task automatic chk(input string name, input int act, input int req);
      nvec++;
      if (act != req) begin
         errs++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Scoreboard monitor: pops on every delivered tap, checks stalls hold their address.
   always @(negedge clk) begin
      vec_t e;
      int   ap, aw;
      if (!reset) begin
         ap = PIPE ? prev_pix : int'(ifc.pix_addr);
         aw = PIPE ? prev_wt  : int'(ifc.wt_addr);
         if (ifc.valid) begin
            vcount++;
            if (q.size() == 0) begin
               nvec++;
               errs++;
               $display("FAIL unexpected_valid: got pix %0d with empty queue", ap);
            end else begin
               e = q.pop_front();
               chk("sb_pix", ap, e.pix);
               chk("sb_wt", aw, e.wt);
               chk("sb_win", int'(ifc.win_idx), e.win);
               chk("sb_last", int'(ifc.last_tap), e.last);
               foreach (tbl[i]) begin
                  if (tbl[i].n == e.n) begin
                     chk("tbl_pix", ap, tbl[i].pix);
                     chk("tbl_wt", aw, tbl[i].wt);
                     chk("tbl_win", int'(ifc.win_idx), tbl[i].win);
                     chk("tbl_last", int'(ifc.last_tap), tbl[i].last);
                  end
               end
            end
         end
         if (ifc.done) chk("done_valid", int'(ifc.valid), 0);
         if (!ifc.enable && !ifc.done && n < NT) begin
            e = model(n);
            chk("stall_pix", int'(ifc.pix_addr), e.pix);
            chk("stall_wt", int'(ifc.wt_addr), e.wt);
         end
         prev_pix = int'(ifc.pix_addr);
         prev_wt  = int'(ifc.wt_addr);
      end
   end

   task automatic do_reset();
      reset       = 1'b1;
      ifc.enable  = 1'b0;
      q.delete();
      n      = 0;
      vcount = 0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Drive enable (steady or random) until done, or until stop_at taps are issued.
   task automatic run_sweep(input bit rnd, input int stop_at, output int first_done);
      int  c = 1;
      int  guard = 0;
      bit  first = 1'b1;
      first_done = 0;
      while (guard < 60000) begin
         if (stop_at >= 0 && n >= stop_at) return;
         ifc.enable = (rnd && !first) ? 1'($urandom_range(0, 1)) : 1'b1;
         first = 1'b0;
         if (ifc.enable && n < NT) begin
            q.push_back(model(n));
            n++;
         end
         @(posedge clk);
         #1;
         c++;
         guard++;
         if (ifc.done) begin
            first_done = c;
            return;
         end
      end
      nvec++;
      errs++;
      $display("FAIL sweep_timeout: got %0d taps issued, expected done within %0d cycles", n, guard);
   endtask

   initial begin
      tbl[0]  = '{0,     0,   0, 0,   0};
      tbl[1]  = '{1,     1,   1, 0,   0};
      tbl[2]  = '{4,     4,   4, 0,   0};
      tbl[3]  = '{5,     28,  5, 0,   0};
      tbl[4]  = '{9,     32,  9, 0,   0};
      tbl[5]  = '{10,    56,  10, 0,  0};
      tbl[6]  = '{20,    112, 20, 0,  0};
      tbl[7]  = '{24,    116, 24, 0,  1};
      tbl[8]  = '{25,    1,   0, 1,   0};
      tbl[9]  = '{599,   139, 24, 23, 1};
      tbl[10] = '{600,   28,  0, 24,  0};
      tbl[11] = '{14399, 783, 24, 575, 1};

      ifc.enable = 1'b0;
      reset      = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", int'(ifc.valid), 0);
      chk("rst_last", int'(ifc.last_tap), 0);
      chk("rst_done", int'(ifc.done), 0);
      chk("rst_pix", int'(ifc.pix_addr), 0);
      chk("rst_wt", int'(ifc.wt_addr), 0);
      chk("rst_win", int'(ifc.win_idx), 0);
      reset = 1'b0;

      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         chk("idle_valid", int'(ifc.valid), 0);
         chk("idle_done", int'(ifc.done), 0);
         chk("idle_pix", int'(ifc.pix_addr), 0);
         chk("idle_wt", int'(ifc.wt_addr), 0);
      end

      do_reset();
      run_sweep(1'b0, -1, fd);
      chk("done_cycle", fd, PIPE ? NT + 2 : NT + 1);
      chk("cont_valid_count", vcount, NT);
      chk("cont_queue_empty", q.size(), 0);

      for (int i = 0; i < 100; i++) begin
         ifc.enable = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         chk("hold_done", int'(ifc.done), 1);
         chk("hold_valid", int'(ifc.valid), 0);
      end

      do_reset();
      run_sweep(1'b1, 3012, fd);
      reset      = 1'b1;
      ifc.enable = 1'b0;
      q.delete();
      n      = 0;
      vcount = 0;
      repeat (2) @(posedge clk);
      #1;
      reset      = 1'b0;
      ifc.enable = 1'b1;
      #1;
      chk("rel_valid", int'(ifc.valid), PIPE ? 0 : 1);
      chk("rel_pix", int'(ifc.pix_addr), 0);
      chk("rel_wt", int'(ifc.wt_addr), 0);
      chk("rel_win", int'(ifc.win_idx), 0);
      chk("rel_done", int'(ifc.done), 0);
      run_sweep(1'b1, -1, fd);
      chk("rand_valid_count", vcount, NT);
      chk("rand_queue_empty", q.size(), 0);
      chk("rand_done", int'(ifc.done), 1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
      $finish;
   end

endmodule
